// File: rtl/micro_ondas_ctrl_param_if.sv
// Keypad/button inputs and display/magnetron outputs of the microwave controller.
// The controller side uses the slave modport; the panel/bench side uses master.
interface micro_ondas_ctrl_param_if #(
    parameter int unsigned MIN_DIGITS = 2
);
    localparam int unsigned ND = MIN_DIGITS + 2;

    logic [9:0]      keypad;
    logic            startn;
    logic            stopn;
    logic            clearn;
    logic            door_closed;
    logic [3:0]      power_sel;
    logic [4*ND-1:0] digits;
    logic            mag_on;
    logic            done;
    logic [1:0]      state;

    modport master (
        output keypad, startn, stopn, clearn, door_closed, power_sel,
        input  digits, mag_on, done, state
    );

    modport slave (
        input  keypad, startn, stopn, clearn, door_closed, power_sel,
        output digits, mag_on, done, state
    );
endinterface

// File: rtl/micro_ondas_ctrl_param.sv
// Microwave controller: keypad time entry, BCD countdown, start/stop/clear, door
// interlock, power-level magnetron duty cycle and a timed done indication.
module micro_ondas_ctrl_param #(
    parameter int unsigned MIN_DIGITS = 2,
    parameter int unsigned TICK_DIV   = 100,
    parameter int unsigned PWR_PERIOD = 10,
    parameter int unsigned DONE_TICKS = 3
) (
    input logic                    clock,
    input logic                    resetn,
    micro_ondas_ctrl_param_if.slave bus
);
    localparam int unsigned ND = MIN_DIGITS + 2;
    localparam int unsigned DW = 4 * ND;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    PWR_MAX   = 4'(PWR_PERIOD);
    localparam logic [3:0]    PHASE_MAX = 4'(PWR_PERIOD - 1);
    localparam logic [CW-1:0] DCNT_MAX  = CW'(DONE_TICKS - 1);

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StCook  = 2'b01;
    localparam logic [1:0] StPause = 2'b10;
    localparam logic [1:0] StDone  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] digits_q, digits_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    phase_q, phase_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          done_q;
    logic          startn_q, stopn_q, clearn_q;
    logic [9:0]    keypad_q;

    logic          start_ev, stop_ev, clear_ev, key_ev, key_onehot, tick;
    logic [3:0]    key_digit;
    logic [3:0]    pwr_eff;
    logic [DW-1:0] digits_dec;
    logic [DW-1:0] digits_shift;
    logic          borrow;

    // Button events are falling edges against the registered history.
    assign start_ev   = startn_q & ~bus.startn;
    assign stop_ev    = stopn_q & ~bus.stopn;
    assign clear_ev   = clearn_q & ~bus.clearn;
    assign key_onehot = (bus.keypad != 10'd0) && ((bus.keypad & (bus.keypad - 10'd1)) == 10'd0);
    assign key_ev     = (keypad_q == 10'd0) && key_onehot;
    assign tick       = (presc_q == PRESC_MAX);

    always_comb begin
        key_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (bus.keypad[k]) key_digit = 4'(k);
        end
    end

    assign digits_shift = {digits_q[DW-5:0], key_digit};

    // One-second BCD decrement: seconds wrap 00 -> 59, borrow ripples through minutes.
    always_comb begin
        digits_dec = digits_q;
        borrow     = 1'b0;
        if (digits_q[3:0] != 4'd0) begin
            digits_dec[3:0] = digits_q[3:0] - 4'd1;
        end else begin
            digits_dec[3:0] = 4'd9;
            if (digits_q[7:4] != 4'd0) begin
                digits_dec[7:4] = digits_q[7:4] - 4'd1;
            end else begin
                digits_dec[7:4] = 4'd5;
                borrow          = 1'b1;
                for (int i = 2; i < ND; i++) begin
                    if (borrow) begin
                        if (digits_q[4*i +: 4] == 4'd0) begin
                            digits_dec[4*i +: 4] = 4'd9;
                        end else begin
                            digits_dec[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                            borrow               = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        phase_d  = phase_q;
        dcnt_d   = dcnt_q;
        case (state_q)
            StIdle: begin
                if (clear_ev) begin
                    digits_d = '0;
                end else if (start_ev) begin
                    if (bus.door_closed && (digits_q != '0)) begin
                        state_d = StCook;
                        presc_d = '0;
                        phase_d = '0;
                    end
                end else if (key_ev) begin
                    digits_d = digits_shift;
                end
            end
            StCook: begin
                if (clear_ev) begin
                    state_d  = StIdle;
                    digits_d = '0;
                end else if (!bus.door_closed || stop_ev) begin
                    state_d = StPause;
                end else if (tick) begin
                    presc_d = '0;
                    phase_d = (phase_q >= PHASE_MAX) ? 4'd0 : phase_q + 4'd1;
                    if (digits_q == DW'(1)) begin
                        digits_d = '0;
                        state_d  = StDone;
                        dcnt_d   = '0;
                    end else begin
                        digits_d = digits_dec;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            StPause: begin
                if (clear_ev) begin
                    state_d  = StIdle;
                    digits_d = '0;
                end else if (bus.door_closed) begin
                    if (stop_ev) begin
                        state_d  = StIdle;
                        digits_d = '0;
                    end else if (start_ev) begin
                        state_d = StCook;
                    end
                end
            end
            default: begin
                if (clear_ev || stop_ev || start_ev) begin
                    state_d  = StIdle;
                    digits_d = '0;
                end else if (key_ev) begin
                    state_d  = StIdle;
                    digits_d = {{(DW-4){1'b0}}, key_digit};
                end else if (tick) begin
                    presc_d = '0;
                    if (dcnt_q == DCNT_MAX) begin
                        state_d = StIdle;
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            digits_q <= '0;
            presc_q  <= '0;
            phase_q  <= '0;
            dcnt_q   <= '0;
            done_q   <= 1'b0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            clearn_q <= 1'b1;
            keypad_q <= 10'd0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            presc_q  <= presc_d;
            phase_q  <= phase_d;
            dcnt_q   <= dcnt_d;
            done_q   <= (state_d == StDone);
            startn_q <= bus.startn;
            stopn_q  <= bus.stopn;
            clearn_q <= bus.clearn;
            keypad_q <= bus.keypad;
        end
    end

    // Interlock is combinational so an opening door cuts the magnetron immediately.
    assign pwr_eff    = (bus.power_sel > PWR_MAX) ? PWR_MAX : bus.power_sel;
    assign bus.mag_on = (state_q == StCook) && bus.door_closed && (phase_q < pwr_eff);
    assign bus.digits = digits_q;
    assign bus.state  = state_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_micro_ondas_ctrl_param.sv
// Self-checking bench: vector table, hand sequences for the multi-cycle corners and a
// randomized run against a decimal-arithmetic reference model.
module tb_micro_ondas_ctrl_param;
    localparam int TD = 4;
    localparam int PP = 10;
    localparam int DT = 3;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    micro_ondas_ctrl_param_if #(.MIN_DIGITS(2)) bus ();

    micro_ondas_ctrl_param #(
        .MIN_DIGITS(2),
        .TICK_DIV  (TD),
        .PWR_PERIOD(PP),
        .DONE_TICKS(DT)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: the time is a plain 4-digit decimal number mm*100+ss.
    int         m_st, m_n, m_presc, m_phase, m_dcnt;
    bit         m_pstart, m_pstop, m_pclear;
    logic [9:0] m_pkey;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic bit m_mag();
        int pe;
        pe = (bus.power_sel > 4'd10) ? 10 : int'(bus.power_sel);
        return (m_st == 1) && bus.door_closed && (m_phase < pe);
    endfunction

    task automatic model_edge();
        bit st_ev, sp_ev, cl_ev, k_ev;
        int kd;
        if (!resetn) begin
            m_st = 0; m_n = 0; m_presc = 0; m_phase = 0; m_dcnt = 0;
            m_pstart = 1; m_pstop = 1; m_pclear = 1; m_pkey = '0;
            return;
        end
        st_ev = m_pstart && !bus.startn;
        sp_ev = m_pstop && !bus.stopn;
        cl_ev = m_pclear && !bus.clearn;
        k_ev  = (m_pkey == 10'd0) && ($countones(bus.keypad) == 1);
        kd = 0;
        for (int k = 0; k < 10; k++) if (bus.keypad[k]) kd = k;
        case (m_st)
            0: begin
                if (cl_ev) m_n = 0;
                else if (st_ev) begin
                    if (bus.door_closed && m_n != 0) begin
                        m_st = 1; m_presc = 0; m_phase = 0;
                    end
                end else if (k_ev) m_n = (m_n * 10 + kd) % 10000;
            end
            1: begin
                if (cl_ev) begin
                    m_st = 0; m_n = 0;
                end else if (!bus.door_closed || sp_ev) m_st = 2;
                else if (m_presc == TD - 1) begin
                    m_presc = 0;
                    m_phase = (m_phase + 1) % PP;
                    if (m_n == 1) begin
                        m_n = 0; m_st = 3; m_dcnt = 0;
                    end else if (m_n % 100 > 0) m_n = m_n - 1;
                    else m_n = m_n - 100 + 59;
                end else m_presc++;
            end
            2: begin
                if (cl_ev) begin
                    m_st = 0; m_n = 0;
                end else if (bus.door_closed && sp_ev) begin
                    m_st = 0; m_n = 0;
                end else if (bus.door_closed && st_ev) m_st = 1;
            end
            default: begin
                if (cl_ev || sp_ev || st_ev) begin
                    m_st = 0; m_n = 0;
                end else if (k_ev) begin
                    m_st = 0; m_n = kd;
                end else if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (m_dcnt == DT - 1) m_st = 0;
                    else m_dcnt++;
                end else m_presc++;
            end
        endcase
        m_pstart = bus.startn; m_pstop = bus.stopn; m_pclear = bus.clearn;
        m_pkey = bus.keypad;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: advance the model, then compare every output against it.
    task automatic step(input string tag);
        logic [19:0] act, exp;
        @(posedge clock);
        model_edge();
        #1;
        act = {bus.digits, bus.state, bus.done, bus.mag_on};
        exp = {to_bcd(m_n), 2'(m_st), m_st == 3, m_mag()};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model/%s: got digits=%h state=%b done=%b mag=%b, expected digits=%h state=%b done=%b mag=%b",
                     tag, act[19:4], act[3:2], act[1], act[0], exp[19:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic key(input int k);
        bus.keypad = 10'b1 << k;
        step("key");
        bus.keypad = 10'd0;
        step("key_rel");
    endtask

    task automatic press_start();
        bus.startn = 1'b0;
        step("start");
        bus.startn = 1'b1;
    endtask

    task automatic press_clear();
        bus.clearn = 1'b0;
        step("clear");
        bus.clearn = 1'b1;
        step("clear_rel");
    endtask

    typedef struct {
        logic [9:0]  key;
        logic        startn;
        logic        clearn;
        logic [15:0] exp_digits;
        logic [1:0]  exp_state;
        logic        exp_mag;
    } vec_t;

    vec_t vecs[18];

    initial begin
        checks = 0;
        errors = 0;
        vecs = '{
            '{10'd0,   1, 1, 16'h0000, 2'b00, 0},
            '{10'd4,   1, 1, 16'h0002, 2'b00, 0},
            '{10'd0,   1, 1, 16'h0002, 2'b00, 0},
            '{10'd2,   1, 1, 16'h0021, 2'b00, 0},
            '{10'd0,   1, 1, 16'h0021, 2'b00, 0},
            '{10'd8,   1, 1, 16'h0213, 2'b00, 0},
            '{10'd0,   1, 1, 16'h0213, 2'b00, 0},
            '{10'd0,   0, 1, 16'h0213, 2'b01, 1},
            '{10'd0,   1, 1, 16'h0213, 2'b01, 1},
            '{10'd0,   1, 1, 16'h0213, 2'b01, 1},
            '{10'd0,   1, 1, 16'h0213, 2'b01, 1},
            '{10'd0,   1, 1, 16'h0212, 2'b01, 1},
            '{10'd6,   1, 1, 16'h0212, 2'b01, 1},
            '{10'd0,   1, 0, 16'h0000, 2'b00, 0},
            '{10'd32,  1, 1, 16'h0005, 2'b00, 0},
            '{10'd32,  1, 1, 16'h0005, 2'b00, 0},
            '{10'd0,   1, 1, 16'h0005, 2'b00, 0},
            '{10'd6,   1, 1, 16'h0005, 2'b00, 0}
        };

        resetn = 1'b0;
        bus.keypad = '0; bus.startn = 1; bus.stopn = 1; bus.clearn = 1;
        bus.door_closed = 1; bus.power_sel = 4'd10;
        step("reset");
        step("reset");
        chk("reset_digits", 32'(bus.digits), 32'h0);
        chk("reset_state", 32'(bus.state), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_mag", 32'(bus.mag_on), 32'h0);
        resetn = 1'b1;

        // Entry, start and first decrement
        for (int i = 0; i < 18; i++) begin
            bus.keypad = vecs[i].key;
            bus.startn = vecs[i].startn;
            bus.clearn = vecs[i].clearn;
            step("vec");
            chk($sformatf("vec%0d_digits", i), 32'(bus.digits), 32'(vecs[i].exp_digits));
            chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d_mag", i), 32'(bus.mag_on), 32'(vecs[i].exp_mag));
        end
        bus.keypad = '0; bus.startn = 1; bus.clearn = 1;
        step("idle");
        press_clear();

        // Minute borrow, DONE and its timed exit
        key(1); key(0); key(0);
        chk("load_0100", 32'(bus.digits), 32'h0100);
        press_start();
        for (int i = 0; i < 4; i++) step("cook");
        chk("borrow_0059", 32'(bus.digits), 32'h0059);
        press_clear();
        key(1);
        press_start();
        for (int i = 0; i < 4; i++) step("cook");
        chk("done_digits", 32'(bus.digits), 32'h0);
        chk("done_state", 32'(bus.state), 32'h3);
        chk("done_flag", 32'(bus.done), 32'h1);
        chk("done_mag", 32'(bus.mag_on), 32'h0);
        for (int i = 0; i < 11; i++) step("done");
        chk("done_hold_state", 32'(bus.state), 32'h3);
        step("done");
        chk("done_exit_state", 32'(bus.state), 32'h0);
        chk("done_exit_flag", 32'(bus.done), 32'h0);

        // Door interlock, pause and resume with frozen prescaler
        key(2); key(5);
        press_start();
        step("cook");
        step("cook");
        bus.door_closed = 1'b0;
        #1;
        chk("door_mag_now", 32'(bus.mag_on), 32'h0);
        step("door");
        chk("door_pause", 32'(bus.state), 32'h2);
        for (int i = 0; i < 8; i++) begin
            step("paused");
            chk("paused_digits", 32'(bus.digits), 32'h0025);
        end
        bus.door_closed = 1'b1;
        press_start();
        chk("resume_state", 32'(bus.state), 32'h1);
        step("resume");
        chk("resume_pre", 32'(bus.digits), 32'h0025);
        step("resume");
        chk("resume_tick", 32'(bus.digits), 32'h0024);

        // Power duty cycle: 3 of every 10 ticks
        press_clear();
        bus.power_sel = 4'd3;
        key(2); key(5);
        press_start();
        for (int c = 0; c < 80; c++) begin
            if (c > 0) step("duty");
            chk($sformatf("duty_c%0d", c), 32'(bus.mag_on), 32'(((c / 4) % 10) < 3));
        end
        bus.power_sel = 4'd10;

        // Stop twice, start with zero, held multi-hot key
        press_clear();
        key(7);
        press_start();
        step("cook");
        bus.stopn = 1'b0;
        step("stop");
        chk("stop_pause", 32'(bus.state), 32'h2);
        bus.stopn = 1'b1;
        step("stop_rel");
        bus.stopn = 1'b0;
        step("stop2");
        chk("stop2_state", 32'(bus.state), 32'h0);
        chk("stop2_digits", 32'(bus.digits), 32'h0);
        bus.stopn = 1'b1;
        press_start();
        chk("start_zero", 32'(bus.state), 32'h0);
        step("idle");
        key(4);
        bus.keypad = 10'b0000000110;
        for (int i = 0; i < 3; i++) begin
            step("multihot");
            chk("multihot_digits", 32'(bus.digits), 32'h0004);
        end
        bus.keypad = '0;
        step("idle");

        // Reset mid-cook; clear beats stop
        press_clear();
        key(0); key(5); key(3); key(0);
        chk("load_0530", 32'(bus.digits), 32'h0530);
        press_start();
        step("cook"); step("cook"); step("cook");
        resetn = 1'b0;
        step("rst");
        chk("rst_digits", 32'(bus.digits), 32'h0);
        chk("rst_state", 32'(bus.state), 32'h0);
        chk("rst_mag", 32'(bus.mag_on), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        resetn = 1'b1;
        step("idle");
        key(5);
        press_start();
        step("cook");
        bus.clearn = 1'b0;
        bus.stopn  = 1'b0;
        step("clr_stop");
        chk("clr_stop_state", 32'(bus.state), 32'h0);
        chk("clr_stop_digits", 32'(bus.digits), 32'h0);
        bus.clearn = 1'b1;
        bus.stopn  = 1'b1;
        step("idle");

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            resetn = ($urandom_range(0, 499) != 0);
            r = $urandom_range(0, 19);
            if (r < 3) bus.keypad = 10'b1 << $urandom_range(0, 9);
            else if (r == 3) bus.keypad = (10'b1 << $urandom_range(0, 9)) | 10'b1;
            else if (r < 8) bus.keypad = bus.keypad;
            else bus.keypad = '0;
            bus.startn = ($urandom_range(0, 9) != 0);
            bus.stopn  = ($urandom_range(0, 24) != 0);
            bus.clearn = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 39) == 0) bus.door_closed = ~bus.door_closed;
            if ($urandom_range(0, 99) == 0) bus.power_sel = 4'($urandom_range(0, 15));
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
